// File: rtl/column_pack_sequencer.sv
// Packs a stream of narrow column elements into wide words.
// Column 0 sits in the LSBs; flush closes a partial word with zero padding.
module column_pack_sequencer #(
    parameter int BIT_WIDTH = 4,
    parameter int COLS      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BIT_WIDTH-1:0]            in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic [COLS*BIT_WIDTH-1:0]       out_data,
    output logic [$clog2(COLS+1)-1:0]       out_count,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int CW = $clog2(COLS);
    localparam int NW = $clog2(COLS + 1);
    localparam int DW = COLS * BIT_WIDTH;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [DW-1:0]   data_q, data_d;
    logic [NW-1:0]   count_q, count_d;

    logic            in_xfer;
    logic            out_xfer;
    logic            last_col;
    logic            close_in;
    logic            step_in;
    logic            close_flush;
    logic [DW-1:0]   written;
    logic [NW-1:0]   fill_cnt;

    // Keep only the first n columns, force the rest to zero.
    function automatic logic [DW-1:0] keep_cols(
        input logic [DW-1:0] d,
        input logic [NW-1:0] n
    );
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++) begin
            if (c < int'(n)) begin
                r[c*BIT_WIDTH +: BIT_WIDTH] = d[c*BIT_WIDTH +: BIT_WIDTH];
            end
        end
        return r;
    endfunction

    // Handshake decodes come straight from registered state.
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_count = count_q;

    assign in_xfer  = in_valid && (state_q == FILL);
    assign out_xfer = out_ready && (state_q == HOLD);
    assign last_col = (col_q == CW'(COLS - 1));
    assign fill_cnt = NW'(col_q) + NW'(1);

    // Current word with the incoming element merged at col_q.
    always_comb begin
        written = data_q;
        for (int c = 0; c < COLS; c++) begin
            if (col_q == CW'(c)) begin
                written[c*BIT_WIDTH +: BIT_WIDTH] = in_data;
            end
        end
    end

    // FILL-state event decode; the three cases are mutually exclusive.
    always_comb begin
        close_in    = in_xfer && (last_col || flush);
        step_in     = in_xfer && !last_col && !flush;
        close_flush = (state_q == FILL) && !in_valid && flush
                      && (col_q != '0);
    end

    // Next-state logic: collect, close, present, release.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        data_d  = data_q;
        count_d = count_q;
        unique case (1'b1)
            close_in: begin
                state_d = HOLD;
                col_d   = '0;
                count_d = fill_cnt;
                data_d  = keep_cols(written, fill_cnt);
            end
            step_in: begin
                col_d  = col_q + CW'(1);
                data_d = written;
            end
            close_flush: begin
                state_d = HOLD;
                col_d   = '0;
                count_d = NW'(col_q);
                data_d  = keep_cols(data_q, NW'(col_q));
            end
            out_xfer: begin
                state_d = FILL;
                data_d  = '0;
                count_d = '0;
            end
            default: begin
            end
        endcase
    end

    // State register with synchronous reset discarding any word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_column_pack_sequencer.sv
// Self-checking bench for column_pack_sequencer.
// Directed vector table, hand sequences, then random traffic vs a queue model.
module tb_column_pack_sequencer;

    logic        clk;
    logic        rst;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    int tests;
    int fails;

    column_pack_sequencer #(
        .BIT_WIDTH(4),
        .COLS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        iv;
        logic [3:0]  d;
        logic        fl;
        logic        ordy;
        logic        eir;
        logic        eov;
        logic [31:0] edata;
        logic [3:0]  ecnt;
        logic [1:0]  chk;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, iv, input logic [3:0] d,
                       input logic fl, ordy, eir, eov,
                       input logic [31:0] edata, input logic [3:0] ecnt,
                       input logic [1:0] chk);
        vec_t v;
        v.r = r; v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
        v.eir = eir; v.eov = eov; v.edata = edata; v.ecnt = ecnt;
        v.chk = chk;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, iv, input logic [3:0] d,
                       input logic fl, ordy);
        rst = r; in_valid = iv; in_data = d; flush = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_word(input logic ordy, input logic fl_last);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b1, 4'(k), fl_last && (k == 8), ordy);
        end
    endtask

    logic [3:0]  m_elems[$];
    bit          m_hold;
    logic [31:0] m_w;
    int          m_c;
    logic [31:0] held;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        add(1,0,0,0,1, 1,0,32'h0,4'd0,2'b11);
        for (int k = 1; k <= 7; k++) add(0,1,4'(k),0,1, 1,0,0,0,0);
        add(0,1,4'd8,0,1, 0,1,32'h87654321,4'd8,2'b11);
        add(0,1,4'hF,0,1, 1,0,32'h0,0,2'b01);
        add(0,1,4'hA,0,1, 1,0,0,0,0);
        add(0,1,4'hB,0,1, 1,0,0,0,0);
        add(0,0,0,1,1, 0,1,32'hBA,4'd2,2'b11);
        add(0,0,0,0,1, 1,0,32'h0,0,2'b01);
        add(0,1,4'h1,0,1, 1,0,0,0,0);
        add(0,1,4'h2,0,1, 1,0,0,0,0);
        add(0,1,4'h3,1,1, 0,1,32'h321,4'd3,2'b11);
        add(0,0,0,0,1, 1,0,32'h0,0,2'b01);
        for (int k = 1; k <= 7; k++) add(0,1,4'(k),0,1, 1,0,0,0,0);
        add(0,1,4'd8,1,1, 0,1,32'h87654321,4'd8,2'b11);
        add(0,0,0,0,1, 1,0,32'h0,0,2'b01);
        add(0,0,0,0,1, 1,0,32'h0,0,2'b01);
        add(0,0,0,1,1, 1,0,32'h0,0,2'b01);
        add(0,1,4'h5,0,1, 1,0,0,0,0);
        add(0,1,4'h6,0,1, 1,0,0,0,0);
        add(0,0,0,1,1, 0,1,32'h65,4'd2,2'b11);
        add(0,0,0,0,1, 1,0,32'h0,0,2'b01);
        for (int k = 1; k <= 7; k++) add(0,1,4'(k),0,0, 1,0,0,0,0);
        add(0,1,4'd8,0,0, 0,1,32'h87654321,4'd8,2'b11);
        add(0,0,0,1,0, 0,1,32'h87654321,4'd8,2'b11);
        add(0,0,0,0,1, 1,0,32'h0,0,2'b01);
        add(0,1,4'hC,1,1, 0,1,32'hC,4'd1,2'b11);
        add(0,0,0,0,1, 1,0,32'h0,0,2'b01);

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
            check($sformatf("vec%0d in_ready", i), 32'(in_ready),
                  32'(tbl[i].eir));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid),
                  32'(tbl[i].eov));
            if (tbl[i].chk[0])
                check($sformatf("vec%0d out_data", i), out_data,
                      tbl[i].edata);
            if (tbl[i].chk[1])
                check($sformatf("vec%0d out_count", i), 32'(out_count),
                      32'(tbl[i].ecnt));
        end

        // Backpressure: word held for five cycles while input pushes.
        feed_word(1'b0, 1'b0);
        check("bp first data", out_data, 32'h87654321);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d data", k), out_data, 32'h87654321);
            check($sformatf("bp%0d count", k), 32'(out_count), 32'd8);
        end
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("bp single transfer", 32'(out_valid), 32'd0);

        // Reset mid-word discards the partial elements.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'h9, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 4'h9, 1'b1, 1'b1);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst data", out_data, 32'h0);
        check("rst count", 32'(out_count), 32'd0);
        feed_word(1'b1, 1'b0);
        check("rst word valid", 32'(out_valid), 32'd1);
        check("rst word data", out_data, 32'h87654321);
        check("rst word count", 32'(out_count), 32'd8);

        // Reset while holding a word drops it.
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        check("rst hold out_valid", 32'(out_valid), 32'd0);
        check("rst hold data", out_data, 32'h0);

        // Random traffic against a queue-based model.
        m_elems.delete();
        m_hold = 0;
        m_w = 0;
        m_c = 0;
        for (int n = 0; n < 1500; n++) begin
            logic r, iv, fl, ordy;
            logic [3:0] d;
            r    = (n == 0) || ($urandom_range(0, 99) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 5) == 0);
            ordy = ($urandom_range(0, 1) == 1);
            d    = 4'($urandom);
            cyc(r, iv, d, fl, ordy);
            if (r) begin
                m_elems.delete();
                m_hold = 0;
            end else if (!m_hold) begin
                if (iv) m_elems.push_back(d);
                if (m_elems.size() == 8 || (fl && m_elems.size() > 0)) begin
                    m_w = 0;
                    foreach (m_elems[k]) m_w |= 32'(m_elems[k]) << (4 * k);
                    m_c = m_elems.size();
                    m_elems.delete();
                    m_hold = 1;
                end
            end else if (ordy) begin
                m_hold = 0;
            end
            check($sformatf("rnd%0d in_ready", n), 32'(in_ready),
                  32'(!m_hold));
            check($sformatf("rnd%0d out_valid", n), 32'(out_valid),
                  32'(m_hold));
            if (m_hold) begin
                check($sformatf("rnd%0d data", n), out_data, m_w);
                check($sformatf("rnd%0d count", n), 32'(out_count),
                      32'(m_c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/column_pack_sequencer.md
COLUMN_PACK_SEQUENCER -- requirements
Module: column_pack_sequencer

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 4: width of one column element.
REQ-002 The block SHALL have parameter COLS, default 8: number of columns per packed word, COLS >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_data, input, BIT_WIDTH bits: incoming column element.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port flush, input, 1 bit: close the current partial word, zero-padding the remaining columns.
REQ-009 The block SHALL have port out_data, output, COLS*BIT_WIDTH bits: packed word.
REQ-010 The block SHALL have port out_count, output, $clog2(COLS+1) bits: number of filled columns in out_data.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data/out_count are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the word.

Function
REQ-013 The block SHALL implement two states: FILL (collecting elements) and HOLD (presenting a word).
REQ-014 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL be 1 exactly in FILL; out_valid SHALL be 1 exactly in HOLD. Both are registered-state decodes with no combinational path from in_valid or out_ready.
REQ-016 Column counter col_idx SHALL range 0..COLS-1 and increment by 1 on each input transfer.
REQ-017 The k-th element of a word (k = 0 first) SHALL be stored at out_data[(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH], so column 0 occupies the LSBs.
REQ-018 An input transfer at col_idx == COLS-1 SHALL store the element, set out_count = COLS, clear col_idx to 0, and move to HOLD on the next cycle.
REQ-019 In FILL, flush with col_idx > 0 and no input transfer SHALL zero columns col_idx..COLS-1, set out_count = col_idx, clear col_idx, and move to HOLD.
REQ-020 If flush coincides with an input transfer, the element SHALL be stored first. The word SHALL then close with out_count = col_idx+1, and columns above it SHALL be zeroed. If that element fills column COLS-1, REQ-018 applies unchanged.
REQ-021 flush in FILL with col_idx == 0 and no input transfer SHALL be ignored; no empty word is ever emitted.
REQ-022 flush in HOLD SHALL be ignored.
REQ-023 In HOLD, out_data and out_count SHALL remain stable until the output transfer.
REQ-024 An output transfer SHALL return the state to FILL on the next cycle and clear the data register to 0.
REQ-025 There SHALL be exactly one bubble cycle (in_ready = 0) per word. Steady-state throughput SHALL be COLS elements per COLS+1 cycles.
REQ-026 The data register SHALL clear to 0 whenever a new word starts, so unfilled columns always read 0.

Reset
REQ-027 When rst = 1 at a clock edge, the block SHALL apply state = FILL, col_idx = 0, out_data = 0, out_count = 0, out_valid = 0, and in_ready = 1 (the FILL decode) after the edge.
REQ-028 rst SHALL override all other inputs in the same cycle. A partial word, or a word held in HOLD, SHALL be discarded without being emitted.

Verification
REQ-029 Full word (BIT_WIDTH=4, COLS=8, out_ready=1): inputs 1..8 on consecutive cycles -> out_data = 0x87654321, out_count = 8, out_valid for 1 cycle, in_ready low that cycle.
REQ-030 Partial flush: inputs 0xA, 0xB, then flush alone -> out_data = 0x000000BA, out_count = 2.
REQ-031 Flush with input: inputs 0x1, 0x2, then 0x3 with flush in the same cycle -> out_data = 0x00000321, out_count = 3. Flush on the 8th element -> out_count = 8, single word only.
REQ-032 Backpressure: full word with out_ready held 0 for 5 cycles -> out_valid stays 1, out_data stable, in_ready stays 0; raise out_ready -> one transfer, then FILL.
REQ-033 Idle flush and flush in HOLD -> no out_valid pulse, col_idx unchanged.
REQ-034 Reset mid-operation: rst after 3 elements, then 8 new elements -> the first word contains only the new elements, with out_count = 8.
